// File: rtl/piso_ser.sv
// Parallel-in serial-out shifter with a one-word holding register so a new word
// can be queued while the previous one is still shifting out, MSB first.
module piso_ser #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             word_done_q, word_done_d;

  logic accept;
  logic in_shift;
  logic last_div;
  logic last_bit;
  logic word_end;
  logic load;

  always_comb begin
    accept   = pi_valid & ~hold_full_q;
    in_shift = (state_q == SHIFT);
    last_div = (div_cnt_q == DIV_LAST);
    last_bit = (bit_cnt_q == BIT_LAST);
    word_end = in_shift & last_div & last_bit;
    // Reload happens on the same edge the LSB finishes, so consecutive words have no gap.
    load     = hold_full_q & (~in_shift | word_end);

    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    hold_full_d = (hold_full_q & ~load) | accept;

    if (accept) begin
      hold_d = pi;
    end

    if (load) begin
      state_d   = SHIFT;
      shift_d   = hold_q;
      bit_cnt_d = '0;
      div_cnt_d = '0;
    end else if (in_shift) begin
      if (last_div) begin
        div_cnt_d = '0;
        if (last_bit) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        div_cnt_d = div_cnt_q + DW'(1);
      end
    end

    // Serial outputs are registered, giving a two-edge accept-to-MSB latency.
    so_valid_d  = in_shift;
    so_d        = in_shift & shift_q[WIDTH-1];
    word_done_d = word_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      so_q        <= 1'b0;
      so_valid_q  <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      so_q        <= so_d;
      so_valid_q  <= so_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign pi_ready  = ~hold_full_q;
  assign so        = so_q;
  assign so_valid  = so_valid_q;
  assign word_done = word_done_q;
  assign busy      = (state_q == SHIFT) | hold_full_q;

endmodule
